xcom_tx_queue: RTL and testbench
================================

XCOM_TX_QUEUE -- requirements
Module: xcom_tx_queue

Interface
REQ-001 The block SHALL have parameter QW_LOG2, default 3, giving a command FIFO depth of 2**QW_LOG2 entries.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: x_clk_i  in  1  link clock, all logic on its rising edge.
REQ-003 x_rst_i  in  1  asynchronous active-high reset.
REQ-004 c_vld_i  in  1  command push strobe, one command per cycle high.
REQ-005 c_rdy_o  out  1  queue not full; push accepted when c_vld_i & c_rdy_o.
REQ-006 c_hd_i  in  8  command header.
REQ-007 c_dt_i  in  32  command data.
REQ-008 flush_i  in  1  single-cycle discard of all queued (not in-flight) entries.
REQ-009 tx_req_o  out  1  request to the TX command stage.
REQ-010 tx_rdy_i  in  1  TX stage ready (high = link idle).
REQ-011 tx_hd_o  out  8  header presented with tx_req_o.
REQ-012 tx_dt_o  out  32  data presented with tx_req_o.
REQ-013 fill_o  out  QW_LOG2+1  number of queued entries, excluding the in-flight entry.
REQ-014 ovf_o  out  1  sticky: push attempted while full; cleared only by reset.
REQ-015 q_st_do  out  2  FSM state debug (IDLE=0, REQ=1, WDONE=2).

Function
REQ-016 The FIFO SHALL store {hd,dt} (40 bits) in first-in/first-out order, using read/write pointers of QW_LOG2+1 bits that wrap modulo 2**(QW_LOG2+1).
REQ-017 Empty SHALL be defined as pointers equal; full SHALL be defined as MSBs differing and the remaining bits equal.
REQ-018 c_rdy_o SHALL equal !full, combinationally from the registered pointers.
REQ-019 A push with c_vld_i high while full SHALL be dropped, SHALL leave the FIFO contents unchanged, and SHALL set ovf_o on the next edge.
REQ-020 A simultaneous push and pop SHALL both take effect, and fill_o SHALL remain unchanged.
REQ-021 fill_o SHALL be registered and SHALL reflect pushes and pops one cycle after the edge on which they occur.
REQ-022 The FSM SHALL have states Q_IDLE, Q_REQ and Q_WDONE.
REQ-023 In Q_IDLE, when the FIFO is not empty and tx_rdy_i is high, the block SHALL pop the head entry into the tx_hd_o/tx_dt_o registers, SHALL set tx_req_o on the same edge, and SHALL go to Q_REQ.
REQ-024 Latency from the push into an empty queue with the link idle to tx_req_o high SHALL be 2 cycles: one cycle for the write and one for the pop.
REQ-025 In Q_REQ, tx_req_o, tx_hd_o and tx_dt_o SHALL be held stable; when tx_rdy_i is sampled low (TX accepted), the block SHALL clear tx_req_o and go to Q_WDONE.
REQ-026 Q_REQ SHALL wait indefinitely for tx_rdy_i low; sync-type headers (hd[7:4]=4'b1000) SHALL NOT be treated specially, because the downstream stage performs the sync wait.
REQ-027 In Q_WDONE, tx_req_o SHALL stay low; when tx_rdy_i is sampled high, the block SHALL go to Q_IDLE.
REQ-028 A new pop SHALL occur no earlier than the cycle after Q_IDLE is re-entered, giving a minimum of one idle-req cycle between commands.
REQ-029 flush_i SHALL set the read pointer equal to the write pointer on the next edge.
REQ-030 A push coincident with flush_i SHALL be discarded.
REQ-031 flush_i SHALL NOT affect the FSM, tx_req_o or the in-flight output registers.
REQ-032 A pop SHALL be suppressed in a cycle where flush_i is high.
REQ-033 tx_hd_o and tx_dt_o SHALL change only on a pop.

Reset
REQ-034 On assertion of x_rst_i, at any time including mid-handshake, all of the following SHALL be cleared asynchronously:
- pointers; fill_o = 0
- tx_req_o = 0; tx_hd_o = 0; tx_dt_o = 0
- ovf_o = 0
- FSM = Q_IDLE
- c_rdy_o therefore = 1
REQ-035 The FIFO storage array SHALL NOT require reset.
REQ-036 After deassertion, the first pop SHALL NOT occur until tx_rdy_i is sampled high.

Verification
REQ-037 Single command: push hd=8'h21, dt=32'hDEADBEEF with tx_rdy_i=1 -> tx_req_o high 2 cycles later with those values; drop tx_rdy_i -> req falls next edge; raise tx_rdy_i -> state returns to 0.
REQ-038 Fill and overflow, QW_LOG2=3, tx_rdy_i=0: 9 pushes -> fill_o=8, c_rdy_o=0, ovf_o=1, 9th entry absent from the drained sequence.
REQ-039 Order: 5 back-to-back pushes with a TX model (accept after 3 cycles, busy for 4) -> 5 handshakes in push order with no duplicates, and tx_req_o never asserted while tx_rdy_i is low in Q_IDLE.
REQ-040 Simultaneous push and pop at fill_o=3 -> fill_o stays 3.
REQ-041 Flush with 4 queued entries and 1 in flight -> in-flight command completes, fill_o=0 next cycle, no further requests.
REQ-042 Reset asserted in Q_REQ with req high -> tx_req_o=0, fill_o=0 and q_st_do=0 immediately, without a clock edge.

Source files
------------

// File: rtl/xcom_tx_queue.sv
// Command queue feeding the TX command stage: a FIFO of {header,data} words
// drained one at a time through a req/ready handshake that completes when the link returns to idle.
module xcom_tx_queue #(
  parameter int QW_LOG2 = 3
) (
  input  logic               x_clk_i,
  input  logic               x_rst_i,
  input  logic               c_vld_i,
  output logic               c_rdy_o,
  input  logic [7:0]         c_hd_i,
  input  logic [31:0]        c_dt_i,
  input  logic               flush_i,
  output logic               tx_req_o,
  input  logic               tx_rdy_i,
  output logic [7:0]         tx_hd_o,
  output logic [31:0]        tx_dt_o,
  output logic [QW_LOG2:0]   fill_o,
  output logic               ovf_o,
  output logic [1:0]         q_st_do
);

  localparam int DEPTH = 2 ** QW_LOG2;

  typedef enum logic [1:0] {
    Q_IDLE  = 2'd0,
    Q_REQ   = 2'd1,
    Q_WDONE = 2'd2
  } q_st_e;

  q_st_e              st_q, st_d;
  logic [QW_LOG2:0]   wr_q, wr_d;
  logic [QW_LOG2:0]   rd_q, rd_d;
  logic [QW_LOG2:0]   fill_q, fill_d;
  logic               req_q, req_d;
  logic [7:0]         hd_q, hd_d;
  logic [31:0]        dt_q, dt_d;
  logic               ovf_q, ovf_d;
  logic [39:0]        mem [DEPTH];
  logic [39:0]        head;

  logic empty, full, push, pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[QW_LOG2] != rd_q[QW_LOG2]) &&
                 (wr_q[QW_LOG2-1:0] == rd_q[QW_LOG2-1:0]);
  assign push  = c_vld_i && !full && !flush_i;
  assign pop   = (st_q == Q_IDLE) && !empty && tx_rdy_i && !flush_i;
  assign head  = mem[rd_q[QW_LOG2-1:0]];

  always_comb begin
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = flush_i ? wr_q : (pop ? rd_q + 1'b1 : rd_q);
    fill_d = wr_d - rd_d;
    ovf_d  = ovf_q | (c_vld_i & full);
  end

  always_comb begin
    st_d  = st_q;
    req_d = req_q;
    hd_d  = hd_q;
    dt_d  = dt_q;
    case (st_q)
      Q_IDLE: begin
        if (pop) begin
          st_d  = Q_REQ;
          req_d = 1'b1;
          hd_d  = head[39:32];
          dt_d  = head[31:0];
        end
      end
      Q_REQ: begin
        // Link going busy is the acceptance; sync headers get no special wait here.
        if (!tx_rdy_i) begin
          st_d  = Q_WDONE;
          req_d = 1'b0;
        end
      end
      Q_WDONE: begin
        if (tx_rdy_i) begin
          st_d = Q_IDLE;
        end
      end
      default: begin
        st_d  = Q_IDLE;
        req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge x_clk_i or posedge x_rst_i) begin
    if (x_rst_i) begin
      st_q   <= Q_IDLE;
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
      req_q  <= 1'b0;
      hd_q   <= '0;
      dt_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
      req_q  <= req_d;
      hd_q   <= hd_d;
      dt_q   <= dt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge x_clk_i) begin
    if (push) begin
      mem[wr_q[QW_LOG2-1:0]] <= {c_hd_i, c_dt_i};
    end
  end

  assign c_rdy_o  = !full;
  assign tx_req_o = req_q;
  assign tx_hd_o  = hd_q;
  assign tx_dt_o  = dt_q;
  assign fill_o   = fill_q;
  assign ovf_o    = ovf_q;
  assign q_st_do  = st_q;

endmodule

// File: tb/tb_xcom_tx_queue.sv
// Bench for xcom_tx_queue: vector table, directed corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_xcom_tx_queue;

  localparam int QW    = 3;
  localparam int DEPTH = 8;

  logic          clk;
  logic          x_rst_i;
  logic          c_vld_i;
  logic          c_rdy_o;
  logic [7:0]    c_hd_i;
  logic [31:0]   c_dt_i;
  logic          flush_i;
  logic          tx_req_o;
  logic          tx_rdy_i;
  logic [7:0]    tx_hd_o;
  logic [31:0]   tx_dt_o;
  logic [QW:0]   fill_o;
  logic          ovf_o;
  logic [1:0]    q_st_do;

  xcom_tx_queue #(.QW_LOG2(QW)) dut (
    .x_clk_i (clk),
    .x_rst_i (x_rst_i),
    .c_vld_i (c_vld_i),
    .c_rdy_o (c_rdy_o),
    .c_hd_i  (c_hd_i),
    .c_dt_i  (c_dt_i),
    .flush_i (flush_i),
    .tx_req_o(tx_req_o),
    .tx_rdy_i(tx_rdy_i),
    .tx_hd_o (tx_hd_o),
    .tx_dt_o (tx_dt_o),
    .fill_o  (fill_o),
    .ovf_o   (ovf_o),
    .q_st_do (q_st_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queued commands, handshake phase (0 idle, 1 req, 2 wait-done).
  logic [39:0] mq[$];
  int          m_st;
  logic        m_req;
  logic [7:0]  m_hd;
  logic [31:0] m_dt;
  logic        m_ovf;

  logic [39:0] exp_q[$];
  logic [39:0] cap_q[$];

  typedef struct {
    logic        vld;
    logic [7:0]  hd;
    logic [31:0] dt;
    logic        fl;
    logic        rdy;
    logic        e_req;
    logic [7:0]  e_hd;
    logic [31:0] e_dt;
    logic [3:0]  e_fill;
    logic        e_crdy;
    logic        e_ovf;
    logic [1:0]  e_st;
  } vec_t;

  vec_t tbl[12];

  function automatic void chk(string nm, logic [39:0] act, logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_st  = 0;
    m_req = 1'b0;
    m_hd  = '0;
    m_dt  = '0;
    m_ovf = 1'b0;
  endfunction

  task automatic cmp_model(string tag);
    chk({tag, ".req"},  {39'd0, tx_req_o}, {39'd0, m_req});
    chk({tag, ".hd"},   {32'd0, tx_hd_o}, {32'd0, m_hd});
    chk({tag, ".dt"},   {8'd0, tx_dt_o}, {8'd0, m_dt});
    chk({tag, ".fill"}, {36'd0, fill_o}, 40'(mq.size()));
    chk({tag, ".crdy"}, {39'd0, c_rdy_o}, {39'd0, (mq.size() != DEPTH)});
    chk({tag, ".ovf"},  {39'd0, ovf_o}, {39'd0, m_ovf});
    chk({tag, ".st"},   {38'd0, q_st_do}, 40'(m_st));
  endtask

  task automatic step(input logic vld, input logic [7:0] hd, input logic [31:0] dt,
                      input logic fl, input logic rdy, input string tag);
    logic full, pop_ok;
    logic [39:0] head;
    int pre_st;
    c_vld_i  = vld;
    c_hd_i   = hd;
    c_dt_i   = dt;
    flush_i  = fl;
    tx_rdy_i = rdy;
    @(posedge clk);
    #1;
    pre_st = m_st;
    full   = (mq.size() == DEPTH);
    head   = '0;
    if (vld && full) m_ovf = 1'b1;
    pop_ok = (m_st == 0) && (mq.size() != 0) && rdy && !fl;
    if (pop_ok) head = mq[0];
    if (fl) mq.delete();
    else begin
      if (pop_ok) void'(mq.pop_front());
      if (vld && !full) mq.push_back({hd, dt});
    end
    case (m_st)
      0: if (pop_ok) begin m_st = 1; m_req = 1'b1; m_hd = head[39:32]; m_dt = head[31:0]; end
      1: if (!rdy) begin m_st = 2; m_req = 1'b0; end
      default: if (rdy) m_st = 0;
    endcase
    cmp_model(tag);
    if (pre_st == 0 && !rdy) chk({tag, ".no_req_busy"}, {39'd0, tx_req_o}, 40'd0);
  endtask

  task automatic do_reset();
    x_rst_i  = 1'b1;
    c_vld_i  = 1'b0;
    c_hd_i   = '0;
    c_dt_i   = '0;
    flush_i  = 1'b0;
    tx_rdy_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    x_rst_i = 1'b0;
    model_reset();
  endtask

  // TX stage model: accepts after seeing req for acc cycles, then stays busy.
  task automatic run_tx(input int npush, input logic [7:0] base, input int acc,
                        input int busy, input int ncyc);
    int wait_c = 0;
    int busy_c = 0;
    logic r;
    logic [31:0] d;
    cap_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (busy_c > 0) begin
        r = 1'b0;
        busy_c--;
      end else if (tx_req_o) begin
        if (wait_c >= acc - 1) begin
          r = 1'b0;
          cap_q.push_back({tx_hd_o, tx_dt_o});
          busy_c = busy - 1;
          wait_c = 0;
        end else begin
          r = 1'b1;
          wait_c++;
        end
      end else begin
        r = 1'b1;
      end
      d = $urandom;
      if (c < npush) begin
        exp_q.push_back({base + 8'(c), d});
        step(1'b1, base + 8'(c), d, 1'b0, r, "tx");
      end else begin
        step(1'b0, 8'h00, 32'h0, 1'b0, r, "tx");
      end
    end
  endtask

  task automatic cmp_handshakes(string tag);
    chk({tag, ".count"}, 40'(cap_q.size()), 40'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk($sformatf("%s.item%0d", tag, i), cap_q[i], exp_q[i]);
  endtask

  int rp[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 8'h21, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,        4'd1, 1'b1, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 1'b1, 8'h21, 32'hDEADBEEF, 4'd0, 1'b1, 1'b0, 2'd1};
    tbl[2]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 1'b1, 8'h21, 32'hDEADBEEF, 4'd0, 1'b1, 1'b0, 2'd1};
    tbl[3]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 8'h21, 32'hDEADBEEF, 4'd0, 1'b1, 1'b0, 2'd2};
    tbl[4]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 8'h21, 32'hDEADBEEF, 4'd0, 1'b1, 1'b0, 2'd2};
    tbl[5]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 1'b0, 8'h21, 32'hDEADBEEF, 4'd0, 1'b1, 1'b0, 2'd0};
    tbl[6]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 1'b0, 8'h21, 32'hDEADBEEF, 4'd0, 1'b1, 1'b0, 2'd0};
    tbl[7]  = '{1'b1, 8'h82, 32'h12345678, 1'b0, 1'b1, 1'b0, 8'h21, 32'hDEADBEEF, 4'd1, 1'b1, 1'b0, 2'd0};
    tbl[8]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 1'b1, 8'h82, 32'h12345678, 4'd0, 1'b1, 1'b0, 2'd1};
    tbl[9]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 1'b1, 8'h82, 32'h12345678, 4'd0, 1'b1, 1'b0, 2'd1};
    tbl[10] = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 8'h82, 32'h12345678, 4'd0, 1'b1, 1'b0, 2'd2};
    tbl[11] = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 1'b0, 8'h82, 32'h12345678, 4'd0, 1'b1, 1'b0, 2'd0};

    model_reset();
    do_reset();
    chk("rst.req",  {39'd0, tx_req_o}, 40'd0);
    chk("rst.fill", {36'd0, fill_o}, 40'd0);
    chk("rst.crdy", {39'd0, c_rdy_o}, 40'd1);
    chk("rst.ovf",  {39'd0, ovf_o}, 40'd0);
    chk("rst.st",   {38'd0, q_st_do}, 40'd0);
    chk("rst.hd",   {32'd0, tx_hd_o}, 40'd0);
    chk("rst.dt",   {8'd0, tx_dt_o}, 40'd0);

    // Single command handshake, then a sync-type header handled identically.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].vld, tbl[i].hd, tbl[i].dt, tbl[i].fl, tbl[i].rdy, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.e_req", i),  {39'd0, tx_req_o}, {39'd0, tbl[i].e_req});
      chk($sformatf("tbl%0d.e_hd", i),   {32'd0, tx_hd_o}, {32'd0, tbl[i].e_hd});
      chk($sformatf("tbl%0d.e_dt", i),   {8'd0, tx_dt_o}, {8'd0, tbl[i].e_dt});
      chk($sformatf("tbl%0d.e_fill", i), {36'd0, fill_o}, {36'd0, tbl[i].e_fill});
      chk($sformatf("tbl%0d.e_crdy", i), {39'd0, c_rdy_o}, {39'd0, tbl[i].e_crdy});
      chk($sformatf("tbl%0d.e_ovf", i),  {39'd0, ovf_o}, {39'd0, tbl[i].e_ovf});
      chk($sformatf("tbl%0d.e_st", i),   {38'd0, q_st_do}, {38'd0, tbl[i].e_st});
    end

    // Fill to capacity with the link busy; the ninth push must be dropped.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      logic [31:0] d;
      d = $urandom;
      if (i < 8) exp_q.push_back({8'h10 + 8'(i), d});
      step(1'b1, 8'h10 + 8'(i), d, 1'b0, 1'b0, "ovf");
    end
    chk("ovf.fill", {36'd0, fill_o}, 40'd8);
    chk("ovf.crdy", {39'd0, c_rdy_o}, 40'd0);
    chk("ovf.flag", {39'd0, ovf_o}, 40'd1);
    run_tx(0, 8'h00, 1, 1, 80);
    cmp_handshakes("ovf_drain");
    chk("ovf.sticky", {39'd0, ovf_o}, 40'd1);

    // Back-to-back pushes against a slow TX stage.
    do_reset();
    exp_q.delete();
    run_tx(5, 8'h40, 3, 4, 80);
    cmp_handshakes("order");

    // Push and pop on the same edge with three queued.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), $urandom, 1'b0, 1'b0, "pp_fill");
    chk("pp.fill_before", {36'd0, fill_o}, 40'd3);
    step(1'b1, 8'h63, $urandom, 1'b0, 1'b1, "pp");
    chk("pp.fill_after", {36'd0, fill_o}, 40'd3);
    chk("pp.req", {39'd0, tx_req_o}, 40'd1);
    chk("pp.hd", {32'd0, tx_hd_o}, 40'h60);

    // Flush with four queued and one in flight.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h50 + 8'(i), $urandom, 1'b0, 1'b1, "fl_fill");
    chk("fl.fill_before", {36'd0, fill_o}, 40'd4);
    chk("fl.req_before", {39'd0, tx_req_o}, 40'd1);
    step(1'b1, 8'h77, $urandom, 1'b1, 1'b1, "fl");
    chk("fl.fill_after", {36'd0, fill_o}, 40'd0);
    chk("fl.req_kept", {39'd0, tx_req_o}, 40'd1);
    chk("fl.hd_kept", {32'd0, tx_hd_o}, 40'h50);
    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, "fl_acc");
    chk("fl.st_wdone", {38'd0, q_st_do}, 40'd2);
    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b1, "fl_idle");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 32'h0, 1'b0, 1'b1, "fl_quiet");
      chk("fl.no_req", {39'd0, tx_req_o}, 40'd0);
    end

    // Asynchronous reset while a request is outstanding.
    do_reset();
    step(1'b1, 8'hA1, 32'h11111111, 1'b0, 1'b1, "ar");
    step(1'b1, 8'hA2, 32'h22222222, 1'b0, 1'b1, "ar");
    chk("ar.req_before", {39'd0, tx_req_o}, 40'd1);
    chk("ar.fill_before", {36'd0, fill_o}, 40'd1);
    #2;
    x_rst_i = 1'b1;
    #1;
    chk("ar.req", {39'd0, tx_req_o}, 40'd0);
    chk("ar.fill", {36'd0, fill_o}, 40'd0);
    chk("ar.st", {38'd0, q_st_do}, 40'd0);
    chk("ar.crdy", {39'd0, c_rdy_o}, 40'd1);
    chk("ar.hd", {32'd0, tx_hd_o}, 40'd0);
    chk("ar.dt", {8'd0, tx_dt_o}, 40'd0);
    do_reset();

    // Randomized traffic with varying link availability.
    rp = '{10, 50, 90, 30, 70, 95};
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, 99) < 60, 8'($urandom), $urandom,
             $urandom_range(0, 99) < 2, $urandom_range(0, 99) < rp[b], "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
